// File: rtl/color_fsm_scheduler.sv
// Round-robin scheduler that shares one Blue/Red colour FSM between two
// requesters, issuing toggles and confirming the result with timeout/retry.
module color_fsm_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] target,
  input  logic [1:0] fsm_out,
  output logic [1:0] fsm_in,
  output logic       busy,
  output logic       gnt_id,
  output logic [1:0] done,
  output logic       err
);

  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] C_BLUE = 2'h1;
  localparam logic [1:0] C_RED  = 2'h2;
  localparam logic [1:0] CMD_TG = 2'h1;
  localparam logic [1:0] CMD_NP = 2'h2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            tgt_q, tgt_d;
  logic            err_q, err_d;
  logic            rr_q, rr_d;
  logic [2:0]      retry_q, retry_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic            sel;
  logic [1:0]      sel_code;
  logic [1:0]      tgt_code;
  logic            last_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      tgt_q   <= 1'b0;
      err_q   <= 1'b0;
      rr_q    <= 1'b0;
      retry_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
    end
  end

  // Both requesting: honour the round-robin pointer.
  assign sel       = (req == 2'b11) ? rr_q : req[1];
  assign sel_code  = target[sel] ? C_RED : C_BLUE;
  assign tgt_code  = tgt_q ? C_RED : C_BLUE;
  assign last_wait = (wait_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    rr_d    = rr_q;
    retry_d = retry_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (|req) begin
          gnt_d   = sel;
          tgt_d   = target[sel];
          retry_d = '0;
          if (fsm_out == sel_code) state_d = S_DONE;
          else                     state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fsm_out == tgt_code) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (last_wait) begin
          if (retry_q < 3'(MAX_RETRIES)) begin
            retry_d = retry_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DONE: begin
        rr_d    = ~gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fsm_in = (state_q == S_ISSUE) ? CMD_TG : CMD_NP;
  assign busy   = (state_q != S_IDLE);
  assign gnt_id = gnt_q;
  assign done   = (state_q != S_DONE) ? 2'b00 :
                  (gnt_q ? 2'b10 : 2'b01);
  assign err    = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_color_fsm_scheduler.sv
// Scoreboard bench for color_fsm_scheduler with a behavioural colour FSM.
module tb_color_fsm_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] target;
  logic [1:0] fsm_out;
  logic [1:0] fsm_in;
  logic       busy;
  logic       gnt_id;
  logic [1:0] done;
  logic       err;

  color_fsm_scheduler #(
    .TIMEOUT_CYCLES(4),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .target(target),
    .fsm_out(fsm_out),
    .fsm_in(fsm_in),
    .busy(busy),
    .gnt_id(gnt_id),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Colour FSM model: resets to Red, 2'h1 toggles.
  logic red_q;
  logic stuck;
  always @(posedge clk) begin
    if (rst) red_q <= 1'b1;
    else if (fsm_in == 2'h1) red_q <= ~red_q;
  end
  assign fsm_out = stuck ? 2'h3 : (red_q ? 2'h2 : 2'h1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  typedef struct {
    bit id;
    bit er;
    int at;
  } exp_t;
  exp_t exp_q[$];

  int issue_n = 0;
  int issue_at[$];
  always @(negedge clk) begin
    if (fsm_in == 2'h1) begin
      issue_n++;
      issue_at.push_back(cyc);
    end
  end

  // Monitor: every done pulse pops one expected job.
  bit chk_clear = 0;
  always @(negedge clk) begin
    if (chk_clear) check("err_clears", {31'd0, err}, 32'd0);
    chk_clear = 0;
    if (done != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_vec", {30'd0, done}, e.id ? 32'd2 : 32'd1);
        check("gnt_id", {31'd0, gnt_id}, {31'd0, e.id});
        check("err", {31'd0, err}, {31'd0, e.er});
        check("done_cycle", cyc, e.at);
        chk_clear = err;
      end
    end
  end

  task automatic push_exp(input bit id, input bit er, input int at);
    exp_t e;
    e.id = id;
    e.er = er;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check("idle_reached", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  int k;
  int i0;

  initial begin
    rst = 1'b1;
    req = 2'b00;
    target = 2'b00;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fsm_in", {30'd0, fsm_in}, 32'd2);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_gnt", {31'd0, gnt_id}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: requester 0 wants Blue, FSM at Red -> one toggle.
    i0 = issue_n;
    k = cyc;
    req = 2'b01;
    target = 2'b00;
    push_exp(1'b0, 1'b0, k + 3);
    @(negedge clk);
    req = 2'b00;
    wait_idle();
    check("t1_issues", issue_n - i0, 32'd1);
    check("t1_fsm_out", {30'd0, fsm_out}, 32'd1);

    // 2: requester 1 wants Red, FSM already Red -> no command.
    do_reset();
    i0 = issue_n;
    k = cyc;
    req = 2'b10;
    target = 2'b10;
    push_exp(1'b1, 1'b0, k + 1);
    @(negedge clk);
    req = 2'b00;
    wait_idle();
    check("t2_issues", issue_n - i0, 32'd0);

    // 3: both held, alternating service 0,1,0.
    do_reset();
    i0 = issue_n;
    k = cyc;
    req = 2'b11;
    target = 2'b10;
    push_exp(1'b0, 1'b0, k + 3);
    push_exp(1'b1, 1'b0, k + 7);
    push_exp(1'b0, 1'b0, k + 11);
    repeat (9) @(negedge clk);
    req = 2'b00;
    wait_idle();
    check("t3_issues", issue_n - i0, 32'd3);

    // 4: stuck FSM output -> 3 issues 5 apart then error.
    do_reset();
    stuck = 1'b1;
    i0 = issue_at.size();
    k = cyc;
    req = 2'b01;
    target = 2'b00;
    push_exp(1'b0, 1'b1, k + 16);
    @(negedge clk);
    req = 2'b00;
    wait_idle();
    check("t4_issues", issue_at.size() - i0, 32'd3);
    if (issue_at.size() - i0 == 3) begin
      check("t4_first", issue_at[i0], k + 1);
      check("t4_gap1", issue_at[i0 + 1] - issue_at[i0], 32'd5);
      check("t4_gap2", issue_at[i0 + 2] - issue_at[i0 + 1], 32'd5);
    end
    stuck = 1'b0;

    // 5: reset in Wait abandons the job and clears rr_ptr.
    do_reset();
    k = cyc;
    req = 2'b01;
    target = 2'b00;
    push_exp(1'b0, 1'b0, k + 3);
    @(negedge clk);
    req = 2'b00;
    wait_idle();
    req = 2'b10;
    target = 2'b10;
    repeat (2) @(negedge clk);
    req = 2'b00;
    check("t5_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_fsm_in", {30'd0, fsm_in}, 32'd2);
    check("t5_done", {30'd0, done}, 32'd0);
    @(negedge clk);
    k = cyc;
    req = 2'b11;
    target = 2'b00;
    push_exp(1'b0, 1'b0, k + 3);
    @(negedge clk);
    req = 2'b00;
    wait_idle();

    // 6: req[0] dropped after grant still completes before requester 1.
    do_reset();
    k = cyc;
    req = 2'b01;
    target = 2'b00;
    push_exp(1'b0, 1'b0, k + 3);
    push_exp(1'b1, 1'b0, k + 7);
    @(negedge clk);
    req = 2'b10;
    target = 2'b10;
    repeat (4) @(negedge clk);
    req = 2'b00;
    wait_idle();

    check("all_done_seen", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
